// File: rtl/stream_packer.sv
// stream_packer: packs SCALE narrow stream words into one wide word with keep/last.
// Build option STREAM_PACKER_MSB_FIRST_EN places the first word of a group in the top lane.
module stream_packer #(
  parameter int DW_IN  = 16,
  parameter int SCALE  = 3,
  parameter int DW_OUT = DW_IN * SCALE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW_IN-1:0]  s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [DW_OUT-1:0] m_data_o,
  output logic [SCALE-1:0]  m_keep_o,
  output logic              m_last_o,
  output logic              m_valid_o,
  input  logic              m_ready_i
);

  localparam int CW = $clog2(SCALE);

  logic [DW_OUT-1:0] acc;
  logic [SCALE-1:0]  acc_keep;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     lane;
  logic [DW_OUT-1:0] acc_nxt;
  logic [SCALE-1:0]  keep_nxt;
  logic              in_fire;
  logic              out_fire;
  logic              done;

  assign s_ready_o = !m_valid_o || m_ready_i;
  assign in_fire   = s_valid_i && s_ready_o;
  assign out_fire  = m_valid_o && m_ready_i;
  assign done      = (cnt == CW'(SCALE - 1)) || s_last_i;

`ifdef STREAM_PACKER_MSB_FIRST_EN
  assign lane = CW'(SCALE - 1) - cnt;
`else
  assign lane = cnt;
`endif

  // Merge the incoming word into its lane of the accumulator
  always_comb begin
    acc_nxt  = acc;
    keep_nxt = acc_keep;
    for (int k = 0; k < SCALE; k++) begin
      if (lane == CW'(k)) begin
        acc_nxt[DW_IN*k +: DW_IN] = s_data_i;
        keep_nxt[k]               = 1'b1;
      end
    end
  end

  // Accumulate words and hand finished groups to the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_keep  <= '0;
      cnt       <= '0;
      m_data_o  <= '0;
      m_keep_o  <= '0;
      m_last_o  <= 1'b0;
      m_valid_o <= 1'b0;
    end else begin
      if (out_fire) begin
        m_valid_o <= 1'b0;
      end
      if (in_fire) begin
        if (done) begin
          m_data_o  <= acc_nxt;
          m_keep_o  <= keep_nxt;
          m_last_o  <= s_last_i;
          m_valid_o <= 1'b1;
          acc       <= '0;
          acc_keep  <= '0;
          cnt       <= '0;
        end else begin
          acc      <= acc_nxt;
          acc_keep <= keep_nxt;
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: scoreboard bench for stream_packer.
// Group-and-pack model plus literal directed expectations.
module tb_stream_packer;

  localparam int DW_IN  = 16;
  localparam int SCALE  = 3;
  localparam int DW_OUT = DW_IN * SCALE;

  typedef struct packed {
    logic [DW_OUT-1:0] data;
    logic [SCALE-1:0]  keep;
    logic              last;
  } out_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW_IN-1:0]  s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready_o;
  logic [DW_OUT-1:0] m_data_o;
  logic [SCALE-1:0]  m_keep_o;
  logic              m_last_o;
  logic              m_valid_o;
  logic              m_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int ready_pct = 100;
  int valid_pct = 100;

  logic [DW_IN-1:0] grp[$];
  out_t exp_q[$];
  out_t cap_q[$];

  stream_packer #(.DW_IN(DW_IN), .SCALE(SCALE)) dut (
    .clk(clk),
    .rst(rst),
    .s_data_i(s_data),
    .s_valid_i(s_valid),
    .s_last_i(s_last),
    .s_ready_o(s_ready_o),
    .m_data_o(m_data_o),
    .m_keep_o(m_keep_o),
    .m_last_o(m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic out_t pack(input bit last);
    out_t e;
    int ln;
    e = '0;
    for (int i = 0; i < grp.size(); i++) begin
`ifdef STREAM_PACKER_MSB_FIRST_EN
      ln = SCALE - 1 - i;
`else
      ln = i;
`endif
      e.data[DW_IN*ln +: DW_IN] = grp[i];
      e.keep[ln] = 1'b1;
    end
    e.last = last;
    return e;
  endfunction

  // scoreboard: compare every cycle, then apply the upcoming transfers
  always @(negedge clk) begin
    if (rst) begin
      grp.delete();
      exp_q.delete();
    end else begin
      chk("ready", 64'(s_ready_o), 64'(!m_valid_o || m_ready));
      chk("valid", 64'(m_valid_o), 64'(exp_q.size() != 0));
      if (m_valid_o && exp_q.size() != 0) begin
        chk("data", 64'(m_data_o), 64'(exp_q[0].data));
        chk("keep", 64'(m_keep_o), 64'(exp_q[0].keep));
        chk("last", 64'(m_last_o), 64'(exp_q[0].last));
      end
      if (m_valid_o && m_ready) begin
        cap_q.push_back({m_data_o, m_keep_o, m_last_o});
        n_out++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_valid && s_ready_o) begin
        grp.push_back(s_data);
        if (grp.size() == SCALE || s_last) begin
          exp_q.push_back(pack(s_last));
          grp.delete();
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW_IN-1:0] d, input bit l);
    bit rdy;
    int n;
    while ($urandom_range(0, 99) >= valid_pct) step();
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_ready_o;
      step();
      n++;
    end while (!rdy && n < 1000);
    if (!rdy) begin
      errors++;
      $display("FAIL send_stall actual=%0d required=<1000", n);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic chk_cap(input string nm, input int idx,
                         input logic [DW_OUT-1:0] d,
                         input logic [SCALE-1:0] k, input bit l);
    if (cap_q.size() > idx) begin
      chk({nm, "_data"}, 64'(cap_q[idx].data), 64'(d));
      chk({nm, "_keep"}, 64'(cap_q[idx].keep), 64'(k));
      chk({nm, "_last"}, 64'(cap_q[idx].last), 64'(l));
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    chk("rst_valid", 64'(m_valid_o), 64'h0);
    chk("rst_data", 64'(m_data_o), 64'h0);
    chk("rst_keep", 64'(m_keep_o), 64'h0);
    chk("rst_last", 64'(m_last_o), 64'h0);
    chk("rst_ready", 64'(s_ready_o), 64'h1);

    // full words
    cap_q.delete();
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0);
    send(16'h4444, 0); send(16'h5555, 0); send(16'h6666, 1);
    repeat (3) step();
    chk("full_n", 64'(cap_q.size()), 64'd2);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk_cap("full0", 0, 48'h111122223333, 3'b111, 0);
    chk_cap("full1", 1, 48'h444455556666, 3'b111, 1);
`else
    chk_cap("full0", 0, 48'h333322221111, 3'b111, 0);
    chk_cap("full1", 1, 48'h666655554444, 3'b111, 1);
`endif

    // partial flush, then single-word packet
    cap_q.delete();
    send(16'hAAAA, 0); send(16'hBBBB, 1); send(16'hCCCC, 1);
    repeat (3) step();
    chk("part_n", 64'(cap_q.size()), 64'd2);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk_cap("part", 0, 48'hAAAABBBB0000, 3'b110, 1);
    chk_cap("single", 1, 48'hCCCC00000000, 3'b100, 1);
`else
    chk_cap("part", 0, 48'h0000BBBBAAAA, 3'b011, 1);
    chk_cap("single", 1, 48'h00000000CCCC, 3'b001, 1);
`endif

    // backpressure
    cap_q.delete();
    ready_pct = 0;
    step(); step();
    fork
      for (int i = 1; i <= 9; i++) send(16'(i), i == 9);
      begin
        repeat (10) step();
        chk("bp_ready_low", 64'(s_ready_o), 64'h0);
        ready_pct = 100;
      end
    join
    repeat (3) step();
    chk("bp_n", 64'(cap_q.size()), 64'd3);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk_cap("bp0", 0, 48'h000100020003, 3'b111, 0);
    chk_cap("bp1", 1, 48'h000400050006, 3'b111, 0);
    chk_cap("bp2", 2, 48'h000700080009, 3'b111, 1);
`else
    chk_cap("bp0", 0, 48'h000300020001, 3'b111, 0);
    chk_cap("bp1", 1, 48'h000600050004, 3'b111, 0);
    chk_cap("bp2", 2, 48'h000900080007, 3'b111, 1);
`endif

    // reset mid-packet
    cap_q.delete();
    send(16'h1234, 0); send(16'h5678, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(16'h9ABC, 0); send(16'hDEF0, 0); send(16'h1357, 0);
    repeat (3) step();
    chk("rstmid_n", 64'(cap_q.size()), 64'd1);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk_cap("rstmid", 0, 48'h9ABCDEF01357, 3'b111, 0);
`else
    chk_cap("rstmid", 0, 48'h1357DEF09ABC, 3'b111, 0);
`endif

    // random soak
    cap_q.delete();
    n_out = 0;
    for (int w = 0; n_out < 3000; w++) begin
      if (w % 100 == 0) begin
        valid_pct = $urandom_range(30, 100);
        ready_pct = $urandom_range(30, 100);
      end
      send(16'($urandom), $urandom_range(0, 4) == 0);
    end
    valid_pct = 100;
    ready_pct = 100;
    send(16'h0F0F, 1);
    repeat (5) step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
